// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op encoding, FSM states and
// small op-class decode helpers used by the top and the iterative unit.
package alu_seq_pkg;

    // Op codes 0-7 keep the values of the original 3-bit combinational ALU.
    typedef enum logic [3:0] {
        Add  = 4'd0,
        Sub  = 4'd1,
        Sfl  = 4'd2,
        Sfr  = 4'd3,
        Equ  = 4'd4,
        Gtr  = 4'd5,
        And  = 4'd6,
        Xor  = 4'd7,
        Mul  = 4'd8,
        Mulh = 4'd9,
        Div  = 4'd10,
        Rem  = 4'd11
    } ALU_Ops_x;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } AluSeq_State;

    // True for the four ops served by the iterative multiply/divide unit.
    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op >= 4'(Mul)) && (op <= 4'(Rem));
    endfunction

    // True for the two ops that run the restoring divider.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == 4'(Div)) || (op == 4'(Rem));
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit
// per clock. A single 2*WIDTH work register holds {hi, lo}: for multiply
// that is the growing product, for divide it is {remainder, quotient}.
// The first step is taken on the start edge straight from the operands, so
// done rises WIDTH-1 cycles later and drops on its own one cycle after.
module alu_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,   // multiplier / dividend
    input  logic [WIDTH-1:0] op_b,   // multiplicand / divisor
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] work_q, work_d, src_work, step_work;
    logic [WIDTH-1:0]   b_q, b_d, src_b;
    logic               is_div_q, is_div_d, src_div;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               running_q, running_d;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic               div_bit;
    logic [WIDTH-1:0]   div_rem;

    // One multiply or divide step on either the fresh operands or the work register.
    always_comb begin
        src_work  = start ? {{WIDTH{1'b0}}, op_a} : work_q;
        src_b     = start ? op_b : b_q;
        src_div   = start ? is_div : is_div_q;
        // Shift-add: add the multiplicand into the top half when the LSB is set.
        mul_sum   = {1'b0, src_work[2*WIDTH-1:WIDTH]} + (src_work[0] ? {1'b0, src_b} : '0);
        // Restoring divide: trial-subtract the divisor from {rem, next dividend bit}.
        div_trial = src_work[2*WIDTH-1:WIDTH-1];
        div_bit   = (div_trial >= {1'b0, src_b});
        div_rem   = div_bit ? WIDTH'(div_trial - {1'b0, src_b}) : div_trial[WIDTH-1:0];
        if (src_div) begin
            step_work = {div_rem, src_work[WIDTH-2:0], div_bit};
        end else begin
            step_work = {mul_sum, src_work[WIDTH-1:1]};
        end
    end

    // Sequencing: load on start, iterate until the counter reaches WIDTH-1, then stop.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the if/else can infer a latch.
        work_d    = work_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        cnt_d     = cnt_q;
        running_d = running_q;
        if (start) begin
            work_d    = step_work;
            b_d       = op_b;
            is_div_d  = is_div;
            cnt_d     = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            if (cnt_q == LAST) begin
                running_d = 1'b0;
            end else begin
                work_d = step_work;
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any partial product or remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            work_q    <= work_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

    assign done = running_q && (cnt_q == LAST);
    assign hi   = work_q[2*WIDTH-1:WIDTH];
    assign lo   = work_q[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// Handshaked, parametrised ALU. Single-cycle ops resolve on the accept edge;
// multiply/divide run in the iterative unit. One op in flight; the result
// and flags are registered and held until the consumer takes them.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_ctrl,
    input  logic [WIDTH-1:0] reg_in,
    input  logic [WIDTH-1:0] acc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rslt_out,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_err
);

    localparam logic [WIDTH:0] SHIFT_LIMIT = (WIDTH + 1)'(WIDTH);

    AluSeq_State      state_q, state_d;
    ALU_Ops_x         op_q, op_d;
    logic [WIDTH-1:0] rslt_q, rslt_d;
    logic             zero_q, zero_d, carry_q, carry_d, err_q, err_d;

    logic             accept;
    logic             md_start, md_is_div, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;

    logic [WIDTH:0]   add_sum;
    logic             shift_oor;
    logic [WIDTH-1:0] fast_rslt;
    logic             fast_carry, fast_err;

    logic             load;
    logic [WIDTH-1:0] load_rslt;
    logic             load_carry, load_err;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign md_is_div = is_div_op(op_ctrl);

    // Single-cycle op results straight from the request inputs.
    always_comb begin
        add_sum    = {1'b0, reg_in} + {1'b0, acc_in};
        shift_oor  = ({1'b0, reg_in} >= SHIFT_LIMIT);
        fast_rslt  = '0;
        fast_carry = 1'b0;
        fast_err   = 1'b0;
        case (ALU_Ops_x'(op_ctrl))
            Add: begin
                fast_rslt  = add_sum[WIDTH-1:0];
                fast_carry = add_sum[WIDTH];
            end
            Sub: begin
                fast_rslt  = reg_in - acc_in;
                fast_carry = (reg_in < acc_in);
            end
            Sfl:     fast_rslt = shift_oor ? '0 : (acc_in << reg_in);
            Sfr:     fast_rslt = shift_oor ? '0 : (acc_in >> reg_in);
            Equ:     fast_rslt = {{(WIDTH-1){1'b0}}, (acc_in == reg_in)};
            Gtr:     fast_rslt = {{(WIDTH-1){1'b0}}, (reg_in > acc_in)};
            And:     fast_rslt = acc_in & reg_in;
            Xor:     fast_rslt = acc_in ^ reg_in;
            // Reserved codes, and Mul..Rem when the iterative unit is absent.
            default: fast_err  = 1'b1;
        endcase
    end

    // FSM next state and result/flag load selection.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        md_start   = 1'b0;
        load       = 1'b0;
        load_rslt  = '0;
        load_carry = 1'b0;
        load_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d = ALU_Ops_x'(op_ctrl);
                    if (MULDIV_EN && is_muldiv_op(op_ctrl)) begin
                        if (md_is_div && (acc_in == '0)) begin
                            // Divide by zero resolves immediately without iterating.
                            load      = 1'b1;
                            load_err  = 1'b1;
                            load_rslt = (op_ctrl == 4'(Div)) ? '1 : reg_in;
                            state_d   = DONE;
                        end else begin
                            md_start = 1'b1;
                            state_d  = BUSY;
                        end
                    end else begin
                        load       = 1'b1;
                        load_rslt  = fast_rslt;
                        load_carry = fast_carry;
                        load_err   = fast_err;
                        state_d    = DONE;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    load      = 1'b1;
                    load_rslt = ((op_q == Mul) || (op_q == Div)) ? md_lo : md_hi;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rslt_d  = load ? load_rslt : rslt_q;
        carry_d = load ? load_carry : carry_q;
        err_d   = load ? load_err : err_q;
        zero_d  = load ? (load_rslt == '0) : zero_q;
    end

    // FSM and registered outputs; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= Add;
            rslt_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rslt_q  <= rslt_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign rslt_out   = rslt_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign flag_err   = err_q;

    if (MULDIV_EN) begin : g_muldiv
        alu_muldiv_iter #(
            .WIDTH (WIDTH)
        ) u_muldiv (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (md_start),
            .is_div (md_is_div),
            .op_a   (reg_in),
            .op_b   (acc_in),
            .done   (md_done),
            .hi     (md_hi),
            .lo     (md_lo)
        );
    end else begin : g_no_muldiv
        assign md_done = 1'b0;
        assign md_hi   = '0;
        assign md_lo   = '0;
    end

endmodule
